// File: rtl/sdram_hexdump.sv
// Hex-address command parser and line-formatted byte dumper sitting between
// the UART pair and the SDRAM controller read port.
module sdram_hexdump #(
  parameter int LINE_BYTES = 16,
  parameter int TIMEOUT    = 1024,
  parameter int ECHO       = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_strobe,
  output logic [7:0]  tx_data,
  output logic        tx_strobe,
  input  logic        tx_ready,
  output logic [24:0] sd_rd_addr,
  output logic        sd_rd_enable,
  input  logic [7:0]  sd_rd_data,
  input  logic        sd_rd_ready,
  input  logic        sd_busy,
  output logic        active
);

  // state   | meaning
  // IDLE    | collect hex digits, wait for '\r', '\n' or '.'
  // ADDR    | emit 7 address digits, MSB first
  // COLON   | emit ':'
  // SP0     | emit ' ' after the colon
  // REQ     | wait for !sd_busy, issue the read
  // WAIT    | wait for sd_rd_ready or timeout
  // HI / LO | emit data nibbles (or '?')
  // SP      | emit ' ', advance byte counter
  // CR / LF | emit line terminator, finish dump
  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_COLON, S_SP0, S_REQ, S_WAIT,
    S_HI, S_LO, S_SP, S_CR, S_LF
  } state_t;

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state;
  logic [24:0]   acc;
  logic [24:0]   start;
  logic [27:0]   shreg;
  logic [2:0]    dig;
  logic [7:0]    cnt;
  logic [TW-1:0] tmo;
  logic [7:0]    rd_byte;
  logic          rd_err;
  logic          tx_pend;
  logic          tx_gap;
  logic          tx_free;
  logic          emitting;
  logic [7:0]    emit_ch;
  logic [4:0]    rx_hex;
  logic          rx_term;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  // {valid, nibble}; letters a-f / A-F share the same low-nibble offset
  function automatic logic [4:0] hex_val(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return {1'b1, c[3:0]};
    if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
      return {1'b1, c[3:0] + 4'd9};
    return 5'h0;
  endfunction

  assign rx_hex  = hex_val(rx_data);
  assign rx_term = (rx_data == 8'h0d) || (rx_data == 8'h0a) || (rx_data == 8'h2e);

  // A queued byte leaves only in a cycle where the UART is ready, and a gap
  // cycle follows every strobe before the next byte is queued.
  assign tx_free      = !tx_pend && !tx_gap;
  assign tx_strobe    = tx_pend && tx_ready && !reset;
  assign sd_rd_enable = (state == S_REQ) && !sd_busy && !reset;

  always_comb begin
    emitting = 1'b1;
    emit_ch  = 8'h20;
    case (state)
      S_ADDR:  emit_ch = hex_char(shreg[27:24]);
      S_COLON: emit_ch = 8'h3a;
      S_SP0:   emit_ch = 8'h20;
      S_HI:    emit_ch = rd_err ? 8'h3f : hex_char(rd_byte[7:4]);
      S_LO:    emit_ch = rd_err ? 8'h3f : hex_char(rd_byte[3:0]);
      S_SP:    emit_ch = 8'h20;
      S_CR:    emit_ch = 8'h0d;
      S_LF:    emit_ch = 8'h0a;
      default: emitting = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      acc        <= '0;
      start      <= '0;
      shreg      <= '0;
      dig        <= '0;
      cnt        <= '0;
      tmo        <= '0;
      rd_byte    <= '0;
      rd_err     <= 1'b0;
      tx_pend    <= 1'b0;
      tx_gap     <= 1'b0;
      tx_data    <= '0;
      sd_rd_addr <= '0;
      active     <= 1'b0;
    end else begin
      tx_gap <= tx_strobe;
      if (tx_strobe) tx_pend <= 1'b0;

      if (emitting && tx_free) begin
        tx_data <= emit_ch;
        tx_pend <= 1'b1;
        case (state)
          S_ADDR: begin
            shreg <= {shreg[23:0], 4'h0};
            dig   <= dig + 3'd1;
            if (dig == 3'd6) state <= S_COLON;
          end
          S_COLON: state <= S_SP0;
          S_SP0: begin
            sd_rd_addr <= start;
            state      <= S_REQ;
          end
          S_HI: state <= S_LO;
          S_LO: state <= S_SP;
          S_SP: begin
            if ({1'b0, cnt} + 9'd1 == 9'(LINE_BYTES)) begin
              state <= S_CR;
            end else begin
              cnt        <= cnt + 8'd1;
              sd_rd_addr <= sd_rd_addr + 25'd1;
              state      <= S_REQ;
            end
          end
          S_CR: state <= S_LF;
          S_LF: begin
            acc    <= start + 25'(LINE_BYTES);
            active <= 1'b0;
            state  <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end else begin
        case (state)
          S_IDLE: begin
            if (rx_strobe) begin
              if (rx_hex[4]) begin
                acc <= {acc[20:0], rx_hex[3:0]};
                if (ECHO != 0 && tx_ready && tx_free) begin
                  tx_data <= rx_data;
                  tx_pend <= 1'b1;
                end
              end else if (rx_term) begin
                start  <= acc;
                shreg  <= {3'b000, acc};
                dig    <= '0;
                cnt    <= '0;
                active <= 1'b1;
                state  <= S_ADDR;
              end
            end
          end
          S_REQ: begin
            if (!sd_busy) begin
              tmo   <= TW'(TIMEOUT - 1);
              state <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (sd_rd_ready) begin
              rd_byte <= sd_rd_data;
              rd_err  <= 1'b0;
              state   <= S_HI;
            end else if (tmo == '0) begin
              rd_err <= 1'b1;
              state  <= S_HI;
            end else begin
              tmo <= tmo - 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sdram_hexdump.sv
// Directed bench for sdram_hexdump: UART capture, SDRAM read responder and
// hand-built expected dump lines.
module tb_sdram_hexdump;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_strobe;
  logic [7:0]  tx_data;
  logic        tx_strobe;
  logic        tx_ready;
  logic [24:0] sd_rd_addr;
  logic        sd_rd_enable;
  logic [7:0]  sd_rd_data;
  logic        sd_rd_ready;
  logic        sd_busy;
  logic        active;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0]  txq[$];
  logic [7:0]  eq[$];
  logic [24:0] rdq[$];
  logic [24:0] ea[$];
  bit          respond_en;
  int          resp_cnt = 0;
  logic [24:0] pend_addr = '0;

  sdram_hexdump #(.LINE_BYTES(16), .TIMEOUT(16), .ECHO(1)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_strobe(rx_strobe),
    .tx_data(tx_data), .tx_strobe(tx_strobe), .tx_ready(tx_ready),
    .sd_rd_addr(sd_rd_addr), .sd_rd_enable(sd_rd_enable),
    .sd_rd_data(sd_rd_data), .sd_rd_ready(sd_rd_ready), .sd_busy(sd_busy),
    .active(active)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [24:0] a);
    return a[7:0] + 8'h5d;
  endfunction

  function automatic logic [7:0] hx(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h61 + {4'h0, n} - 8'd10);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // UART capture and SDRAM responder (3-cycle read latency when enabled)
  always @(negedge clk) begin
    if (tx_strobe === 1'b1) begin
      txq.push_back(tx_data);
      chk("strobe_needs_ready", 32'(tx_ready), 32'd1);
    end
    sd_rd_ready = 1'b0;
    if (resp_cnt != 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        sd_rd_ready = 1'b1;
        sd_rd_data  = mem_byte(pend_addr);
      end
    end
    if (sd_rd_enable === 1'b1) begin
      rdq.push_back(sd_rd_addr);
      chk("rd_while_busy", 32'(sd_busy), 32'd0);
      if (respond_en) begin
        pend_addr = sd_rd_addr;
        resp_cnt  = 3;
      end
    end
  end

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) eq.push_back(s[i]);
  endtask

  task automatic build_line(input logic [24:0] st, input bit err);
    logic [27:0] a;
    logic [7:0]  d;
    a = {3'b000, st};
    for (int i = 0; i < 7; i++) eq.push_back(hx(a[27-4*i -: 4]));
    push_str(": ");
    for (int b = 0; b < 16; b++) begin
      d = mem_byte(st + 25'(b));
      ea.push_back(st + 25'(b));
      if (err) push_str("??");
      else begin
        eq.push_back(hx(d[7:4]));
        eq.push_back(hx(d[3:0]));
      end
      push_str(" ");
    end
    eq.push_back(8'h0d);
    eq.push_back(8'h0a);
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_strobe = 1'b1;
    @(posedge clk); #1;
    rx_strobe = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_rx(s[i]);
  endtask

  task automatic wait_idle(input string tag);
    int cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (active === 1'b1 && cyc < 3000);
    chk({tag, "_done"}, 32'(active), 32'd0);
    repeat (6) @(negedge clk);
  endtask

  task automatic check_tx(input string tag);
    int bad = -1;
    logic [7:0] o = '0;
    logic [7:0] e = '0;
    chk({tag, "_len"}, 32'(txq.size()), 32'(eq.size()));
    for (int i = 0; i < txq.size() && i < eq.size(); i++)
      if (bad < 0 && txq[i] !== eq[i]) begin
        bad = i; o = txq[i]; e = eq[i];
      end
    n_chk++;
    assert (bad === -1) else begin
      n_fail++;
      $error("FAIL %s_data: index %0d observed %02h expected %02h", tag, bad, o, e);
    end
    txq.delete();
    eq.delete();
  endtask

  task automatic check_rd(input string tag);
    int bad = -1;
    logic [24:0] o = '0;
    logic [24:0] e = '0;
    chk({tag, "_rdlen"}, 32'(rdq.size()), 32'(ea.size()));
    for (int i = 0; i < rdq.size() && i < ea.size(); i++)
      if (bad < 0 && rdq[i] !== ea[i]) begin
        bad = i; o = rdq[i]; e = ea[i];
      end
    n_chk++;
    assert (bad === -1) else begin
      n_fail++;
      $error("FAIL %s_rdaddr: index %0d observed %07h expected %07h", tag, bad, o, e);
    end
    rdq.delete();
    ea.delete();
  endtask

  initial begin
    int sz;
    int nr;
    reset = 1'b1; rx_data = '0; rx_strobe = 1'b0; tx_ready = 1'b1;
    sd_rd_data = '0; sd_rd_ready = 1'b0; sd_busy = 1'b0; respond_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_strobe", 32'(tx_strobe), 32'd0);
    chk("rst_rd_enable", 32'(sd_rd_enable), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_rd_addr", 32'(sd_rd_addr), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // "1a3\n": echo plus first dump line
    push_str("1a3");
    build_line(25'h1a3, 1'b0);
    send_str("1a3\n");
    chk("active_1a3", 32'(active), 32'd1);
    wait_idle("l1a3");
    check_tx("l1a3");
    check_rd("l1a3");

    // "." continues at start+16
    build_line(25'h1b3, 1'b0);
    send_str(".");
    wait_idle("l1b3");
    check_tx("l1b3");
    check_rd("l1b3");

    // address wrap at 2^25
    push_str("1ffffff");
    build_line(25'h1ffffff, 1'b0);
    send_str("1ffffff\n");
    wait_idle("lwrap");
    check_tx("lwrap");
    check_rd("lwrap");

    // controller busy stalls the first request
    @(posedge clk); #1;
    sd_busy = 1'b1;
    build_line(25'h000000f, 1'b0);
    send_rx(8'h2e);
    repeat (50) @(negedge clk);
    chk("busy_no_rd", 32'(rdq.size()), 32'd0);
    @(posedge clk); #1;
    sd_busy = 1'b0;
    repeat (2) @(negedge clk);
    chk("busy_single_rd", 32'(rdq.size()), 32'd1);
    wait_idle("lbusy");
    check_tx("lbusy");
    check_rd("lbusy");

    // no read responses: every byte times out
    respond_en = 1'b0;
    build_line(25'h000001f, 1'b1);
    send_str(".");
    wait_idle("ltmo");
    check_tx("ltmo");
    check_rd("ltmo");
    respond_en = 1'b1;

    // tx_ready low mid-line with stray rx bytes
    build_line(25'h000002f, 1'b0);
    send_str(".");
    repeat (20) @(negedge clk);
    @(posedge clk); #1;
    tx_ready = 1'b0;
    sz = txq.size();
    send_str("7.\n");
    repeat (85) @(negedge clk);
    chk("stall_no_tx", 32'(txq.size()), 32'(sz));
    @(posedge clk); #1;
    tx_ready = 1'b1;
    wait_idle("lstall");
    check_tx("lstall");
    check_rd("lstall");

    // stray bytes left acc at start+16
    build_line(25'h000003f, 1'b0);
    send_str(".");
    wait_idle("lstray");
    check_tx("lstray");
    check_rd("lstray");

    // reset in the middle of a dump
    send_str(".");
    repeat (40) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_tx_strobe", 32'(tx_strobe), 32'd0);
    chk("mid_rst_rd_enable", 32'(sd_rd_enable), 32'd0);
    chk("mid_rst_active", 32'(active), 32'd0);
    chk("mid_rst_tx_data", 32'(tx_data), 32'd0);
    chk("mid_rst_rd_addr", 32'(sd_rd_addr), 32'd0);
    sz = txq.size();
    nr = rdq.size();
    repeat (200) @(negedge clk);
    chk("post_rst_no_tx", 32'(txq.size()), 32'(sz));
    chk("post_rst_no_rd", 32'(rdq.size()), 32'(nr));
    txq.delete();
    rdq.delete();

    // accumulator cleared by reset
    build_line(25'h0000000, 1'b0);
    send_str(".");
    wait_idle("lzero");
    check_tx("lzero");
    check_rd("lzero");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
